// File: rtl/fsa_scan_if.sv
// Scan-controller command/read bus: a requester (master) issues frame scans,
// the controller (slave) emits the raster read strobe, position and edge flags.
interface fsa_scan_if #(
  parameter int unsigned C_IMG_WW = 12,
  parameter int unsigned C_IMG_HW = 12
);
  logic                start;
  logic [C_IMG_WW-1:0] img_w;
  logic [C_IMG_HW-1:0] img_h;
  logic                abort;

  logic                busy;
  logic                rd_en;
  logic [C_IMG_WW-1:0] x;
  logic [C_IMG_HW-1:0] y;
  logic                hfirst;
  logic                hlast;
  logic                hM2;
  logic                hM3;
  logic                wfirst;
  logic                wlast;
  logic                sof;
  logic                done;
  logic                err;

  modport master (
    output start, img_w, img_h, abort,
    input  busy, rd_en, x, y, hfirst, hlast, hM2, hM3, wfirst, wlast, sof, done, err
  );

  modport slave (
    input  start, img_w, img_h, abort,
    output busy, rd_en, x, y, hfirst, hlast, hM2, hM3, wfirst, wlast, sof, done, err
  );
endinterface

// File: rtl/fsa_scan_ctl.sv
// Frame scan controller: walks a W x H raster one read per cycle, flags the
// frame/row/column edges for the edge detector, then waits C_DRAIN cycles for
// the detector pipeline to empty before pulsing done.
// Build option: define FSA_SCAN_GAP_EN to insert one idle cycle between rows.
module fsa_scan_ctl #(
  parameter int unsigned C_IMG_WW = 12,
  parameter int unsigned C_IMG_HW = 12,
  parameter int unsigned C_DRAIN  = 6
) (
  input  logic        clk,
  input  logic        resetn,
  fsa_scan_if.slave   bus
);

  localparam int unsigned CNT_W = (C_DRAIN > 1) ? $clog2(C_DRAIN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LINE  = 2'd1,
    DRAIN = 2'd2
`ifdef FSA_SCAN_GAP_EN
    ,
    GAP   = 2'd3
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [C_IMG_WW-1:0] w_q, w_d;
  logic [C_IMG_HW-1:0] h_q, h_d;
  logic [C_IMG_WW-1:0] x_q, x_d;
  logic [C_IMG_HW-1:0] y_q, y_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic busy_q,   busy_d;
  logic rd_en_q,  rd_en_d;
  logic sof_q,    sof_d;
  logic done_q,   done_d;
  logic err_q,    err_d;
  logic hfirst_q, hfirst_d;
  logic hlast_q,  hlast_d;
  logic hm2_q,    hm2_d;
  logic hm3_q,    hm3_d;
  logic wfirst_q, wfirst_d;
  logic wlast_q,  wlast_d;

  logic go_drain;

  // Next-state, next read position and registered-output values
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    h_d      = h_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    rd_en_d  = 1'b0;
    sof_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    go_drain = 1'b0;

    case (state_q)
      IDLE: begin
        x_d = '0;
        y_d = '0;
        if (bus.start) begin
          if ((bus.img_w != '0) && (bus.img_h != '0)) begin
            w_d     = bus.img_w;
            h_d     = bus.img_h;
            state_d = LINE;
            rd_en_d = 1'b1;
            sof_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LINE: begin
        if (bus.abort) begin
          go_drain = 1'b1;
        end else if (x_q == w_q - C_IMG_WW'(1)) begin
          if (y_q == h_q - C_IMG_HW'(1)) begin
            go_drain = 1'b1;
          end else begin
            x_d = '0;
            y_d = y_q + C_IMG_HW'(1);
`ifdef FSA_SCAN_GAP_EN
            state_d = GAP;
`else
            rd_en_d = 1'b1;
`endif
          end
        end else begin
          x_d     = x_q + C_IMG_WW'(1);
          rd_en_d = 1'b1;
        end
      end

`ifdef FSA_SCAN_GAP_EN
      GAP: begin
        if (bus.abort) begin
          go_drain = 1'b1;
        end else begin
          state_d = LINE;
          rd_en_d = 1'b1;
        end
      end
`endif

      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          done_d = (cnt_q == CNT_W'(1));
        end
      end

      default: state_d = IDLE;
    endcase

    // Drain counts down so done lands on the final drain cycle
    if (go_drain) begin
      state_d = DRAIN;
      cnt_d   = CNT_W'(C_DRAIN - 1);
      done_d  = (C_DRAIN == 1);
    end

    busy_d = (state_d != IDLE);

    // hfirst idles high so the cycle carrying start already shows it,
    // letting downstream per-frame state clear before sof.
    hfirst_d = (state_d == IDLE) | (rd_en_d & (y_d == '0));
    hlast_d  = rd_en_d & (y_d == h_d - C_IMG_HW'(1));
    hm2_d    = rd_en_d & (h_d >= C_IMG_HW'(2)) & (y_d == h_d - C_IMG_HW'(2));
    hm3_d    = rd_en_d & (h_d >= C_IMG_HW'(3)) & (y_d == h_d - C_IMG_HW'(3));
    wfirst_d = rd_en_d & (x_d == '0);
    wlast_d  = rd_en_d & (x_d == w_d - C_IMG_WW'(1));
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      w_q      <= '0;
      h_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      sof_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hfirst_q <= 1'b0;
      hlast_q  <= 1'b0;
      hm2_q    <= 1'b0;
      hm3_q    <= 1'b0;
      wfirst_q <= 1'b0;
      wlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      h_q      <= h_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      rd_en_q  <= rd_en_d;
      sof_q    <= sof_d;
      done_q   <= done_d;
      err_q    <= err_d;
      hfirst_q <= hfirst_d;
      hlast_q  <= hlast_d;
      hm2_q    <= hm2_d;
      hm3_q    <= hm3_d;
      wfirst_q <= wfirst_d;
      wlast_q  <= wlast_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.rd_en  = rd_en_q;
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.sof    = sof_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.hfirst = hfirst_q;
  assign bus.hlast  = hlast_q;
  assign bus.hM2    = hm2_q;
  assign bus.hM3    = hm3_q;
  assign bus.wfirst = wfirst_q;
  assign bus.wlast  = wlast_q;

endmodule

// File: tb/tb_fsa_scan_ctl.sv
// Bench for fsa_scan_ctl: directed vector table, random frames against a
// raster-list reference model, and an asynchronous mid-scan reset sequence.
module tb_fsa_scan_ctl;

  localparam int unsigned WW = 12;
  localparam int unsigned HW = 12;
  localparam int unsigned D  = 6;
`ifdef FSA_SCAN_GAP_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif

  logic clk;
  logic resetn;

  fsa_scan_if #(.C_IMG_WW(WW), .C_IMG_HW(HW)) bus();

  fsa_scan_ctl #(.C_IMG_WW(WW), .C_IMG_HW(HW), .C_DRAIN(D)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One expected output cycle of the model
  typedef struct {
    bit busy, rd, sof, done, err, drain;
    int x, y, k;
  } exp_t;

  function automatic exp_t mk(bit b, bit r, bit s, bit d, bit e, bit dr, int x, int y, int k);
    exp_t t;
    t.busy = b; t.rd = r; t.sof = s; t.done = d; t.err = e; t.drain = dr;
    t.x = x; t.y = y; t.k = k;
    return t;
  endfunction

  // Run one start request; model builds the full expected cycle list from the
  // raster order (rows of W reads, optional gaps, abort cut-off, drain).
  task automatic run_frame(input int w, input int h, input int ab, input bit ab0,
                           output int reads, output int done_cyc, output int errs);
    exp_t q[$];
    exp_t e;
    int   n;
    bit   stop;
    logic [29:0] exp_pos;

    if (w == 0 || h == 0) begin
      q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    end else begin
      n = 0;
      stop = 0;
      for (int yy = 0; yy < h; yy++) begin
        for (int xx = 0; xx < w; xx++) begin
          if (!stop) begin
            n++;
            q.push_back(mk(1, 1, n == 1, 0, 0, 0, xx, yy, n));
            if (n == ab) stop = 1;
          end
        end
        if (!stop && yy < h - 1 && G == 1) q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      for (int i = 0; i < int'(D); i++) q.push_back(mk(1, 0, 0, i == int'(D) - 1, 0, 1, 0, 0, 0));
    end
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(negedge clk);
    chk("pre_start_hfirst", {bus.rd_en, bus.busy, bus.hfirst}, 3'b001);
    bus.start = 1'b1;
    bus.img_w = WW'(w);
    bus.img_h = HW'(h);
    bus.abort = ab0;

    reads = 0;
    done_cyc = 0;
    errs = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      e = q[i];
      chk($sformatf("ctl_w%0d_h%0d_c%0d", w, h, i + 1),
          {bus.busy, bus.rd_en, bus.sof, bus.done, bus.err},
          {e.busy, e.rd, e.sof, e.done, e.err});
      if (!e.busy) chk($sformatf("idle_hfirst_c%0d", i + 1), bus.hfirst, 1'b1);
      if (e.rd) begin
        exp_pos = {WW'(e.x), HW'(e.y), e.y == 0, e.y == h - 1, e.y == h - 2,
                   e.y == h - 3, e.x == 0, e.x == w - 1};
        chk($sformatf("pos_w%0d_h%0d_k%0d", w, h, e.k),
            {bus.x, bus.y, bus.hfirst, bus.hlast, bus.hM2, bus.hM3, bus.wfirst, bus.wlast},
            exp_pos);
      end
      if (bus.rd_en) reads++;
      if (bus.done) done_cyc = i + 1;
      if (bus.err) errs++;
      // Noise while busy: start/dimension changes and drain-time aborts are ignored
      bus.start = e.busy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.img_w = WW'($urandom);
      bus.img_h = HW'($urandom);
      bus.abort = (e.rd && e.k == ab) ? 1'b1 : (e.drain ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.img_w = '0;
    bus.img_h = '0;
  endtask

  typedef struct {
    int w, h, ab;
    bit ab0;
    int reads, done_cyc, errs;
  } vec_t;

  vec_t vt[12];
  int r, dc, ec;
  int rw, rh, rab;

  initial begin
    vt[0]  = '{4, 4, 0, 0, 16, 16 + 3*G + D, 0};
    vt[1]  = '{3, 2, 0, 0, 6, 6 + G + D, 0};
    vt[2]  = '{5, 0, 0, 0, 0, 0, 1};
    vt[3]  = '{0, 3, 0, 0, 0, 0, 1};
    vt[4]  = '{8, 8, 5, 0, 5, 5 + D, 0};
    vt[5]  = '{1, 1, 0, 0, 1, 1 + D, 0};
    vt[6]  = '{2, 3, 0, 0, 6, 6 + 2*G + D, 0};
    vt[7]  = '{2, 2, 4, 0, 4, 4 + G + D, 0};
    vt[8]  = '{3, 3, 0, 1, 9, 9 + 2*G + D, 0};
    vt[9]  = '{4095, 2, 0, 0, 8190, 8190 + G + D, 0};
    vt[10] = '{1, 4095, 0, 0, 4095, 4095 + 4094*G + D, 0};
    vt[11] = '{3, 4, 4, 0, 4, 4 + G + D, 0};

    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.img_w = '0;
    bus.img_h = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {bus.busy, bus.rd_en, bus.sof, bus.done, bus.err, bus.hfirst, bus.hlast,
         bus.hM2, bus.hM3, bus.wfirst, bus.wlast, bus.x, bus.y}, '0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_frame(vt[i].w, vt[i].h, vt[i].ab, vt[i].ab0, r, dc, ec);
      chk($sformatf("tbl%0d_reads", i), r, vt[i].reads);
      chk($sformatf("tbl%0d_done_cycle", i), dc, vt[i].done_cyc);
      chk($sformatf("tbl%0d_err", i), ec, vt[i].errs);
    end

    for (int i = 0; i < 30; i++) begin
      rw  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 9));
      rh  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 9));
      rab = ($urandom_range(0, 2) == 0 && rw * rh > 0) ? int'($urandom_range(1, rw * rh)) : 0;
      run_frame(rw, rh, rab, 1'($urandom_range(0, 3) == 0), r, dc, ec);
    end

    // Asynchronous reset in the middle of a row, then a fresh 1x1 frame
    @(negedge clk);
    bus.start = 1'b1;
    bus.img_w = WW'(8);
    bus.img_h = HW'(8);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrow_rd_en", {bus.rd_en, bus.busy}, 2'b11);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_outputs",
        {bus.busy, bus.rd_en, bus.sof, bus.done, bus.err, bus.hfirst, bus.hlast,
         bus.hM2, bus.hM3, bus.wfirst, bus.wlast, bus.x, bus.y}, '0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < int'(D) + 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset_quiet_c%0d", i), {bus.busy, bus.rd_en, bus.done}, 3'b000);
    end
    run_frame(1, 1, 0, 0, r, dc, ec);
    chk("post_reset_1x1_reads", r, 1);
    chk("post_reset_1x1_done_cycle", dc, 1 + D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fsa_scan_ctl.md
FSA_SCAN_CTL -- requirements
Module: fsa_scan_ctl

Interface
REQ-001 SHALL have parameter C_IMG_WW, default 12, column-count/x width.
REQ-002 SHALL have parameter C_IMG_HW, default 12, row-count/y width.
REQ-003 SHALL have parameter C_DRAIN, default 6, cycles from last read to done (edge-detect pipeline depth).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to scan one frame.
REQ-007 img_w  in  C_IMG_WW  columns per row, sampled on accepted start.
REQ-008 img_h  in  C_IMG_HW  rows per frame, sampled on accepted start.
REQ-009 abort  in  1  cancel scan in progress.
REQ-010 busy  out  1  scan or drain in progress.
REQ-011 rd_en  out  1  read strobe to analysis RAM / edge detector.
REQ-012 x  out  C_IMG_WW  column of current read.
REQ-013 y  out  C_IMG_HW  row of current read.
REQ-014 hfirst, hlast, hM2, hM3  out  1 each  row flags: y==0, y==H-1, y==H-2, y==H-3.
REQ-015 wfirst, wlast  out  1 each  column flags: x==0, x==W-1.
REQ-016 sof  out  1  one-cycle pulse with first rd_en of frame.
REQ-017 done  out  1  one-cycle pulse, results final.
REQ-018 err  out  1  one-cycle pulse, start rejected (img_w==0 or img_h==0).

Function
REQ-019 SHALL implement states IDLE, LINE, GAP, DRAIN; all outputs registered.
REQ-020 IDLE: start with img_w!=0 and img_h!=0 SHALL latch W/H, go LINE; first rd_en, sof, x=0, y=0 on cycle after start.
REQ-021 IDLE: start with zero dimension SHALL pulse err next cycle, stay IDLE, no rd_en.
REQ-022 LINE: one rd_en per cycle, x increments 0..W-1; at x==W-1 y increments, x wraps to 0.
REQ-023 Row flags SHALL be valid with every rd_en and stable across the row; flags for rows absent when H<3 (e.g. hM3 at H=2) SHALL never assert.
REQ-024 hfirst SHALL also be asserted (rd_en low) for one cycle on the cycle before sof, so downstream per-frame state clears.
REQ-025 After read (W-1,H-1), SHALL enter DRAIN, rd_en low, count C_DRAIN cycles, pulse done on last, return IDLE.
REQ-026 busy SHALL be high from cycle after accepted start through the done cycle inclusive.
REQ-027 start while busy SHALL be ignored; img_w/img_h changes while busy SHALL have no effect.
REQ-028 abort in LINE/GAP SHALL drop rd_en next cycle and enter DRAIN; done still pulses after C_DRAIN; abort in DRAIN/IDLE ignored.
REQ-029 start and abort in same IDLE cycle: start SHALL win.
REQ-030 W=1 and H=1 SHALL yield exactly one rd_en with hfirst, hlast, wfirst, wlast all high.
REQ-031 Counters SHALL not overflow: max W=2^C_IMG_WW-1, H=2^C_IMG_HW-1.

Reset
REQ-032 resetn low SHALL force IDLE asynchronously; busy, rd_en, sof, done, err, all flags =0; x=0, y=0.
REQ-033 Reset mid-scan SHALL produce no done; first start after release SHALL behave as REQ-020.

Configuration
REQ-034 Macro FSA_SCAN_GAP_EN defined: after each row's last read, one GAP cycle (rd_en low) before next row; not inserted after last row.
REQ-035 Macro undefined: GAP state not built; rows back-to-back; frame read time exactly W*H cycles.

Verification
REQ-036 W=4,H=4, start at cycle 0 -> rd_en cycles 1..16, sof cycle 1, hM3 on y=1 reads, done cycle 22, busy 1..22 (no gap).
REQ-037 W=3,H=2 -> hM3 never high, hM2 on y=0, hlast on y=1, wlast at x=2 each row, 6 rd_en.
REQ-038 start with img_h=0 -> err pulse cycle 1, busy stays 0, no rd_en.
REQ-039 W=8,H=8, abort on 5th rd_en cycle -> rd_en low next cycle, done C_DRAIN cycles later, no further reads.
REQ-040 FSA_SCAN_GAP_EN, W=2,H=3 -> rd_en pattern 11011011, done at cycle 8+C_DRAIN.
REQ-041 resetn low mid-row then released, new start W=1,H=1 -> single rd_en with all four edge flags high, done at cycle 1+C_DRAIN.
